// File: rtl/axi_rr_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single AXI3-style DDR port.
// One transaction is in flight at a time; the owner keeps the port until B or the last R beat.
module axi_rr_port_arbiter #(
  parameter int DW      = 256,
  parameter int TIMEOUT = 4096
) (
  input  logic              axi_clk,
  input  logic              rst,
  input  logic [2*47-1:0]   s_acmd,
  input  logic [1:0]        s_atype,
  input  logic [1:0]        s_avalid,
  output logic [1:0]        s_aready,
  input  logic [2*DW-1:0]   s_wdata,
  input  logic [2*DW/8-1:0] s_wstrb,
  input  logic [1:0]        s_wlast,
  input  logic [1:0]        s_wvalid,
  output logic [1:0]        s_wready,
  output logic [DW-1:0]     s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic [1:0]        s_rvalid,
  input  logic [1:0]        s_rready,
  output logic [1:0]        s_bvalid,
  input  logic [1:0]        s_bready,
  output logic [7:0]        m_aid,
  output logic [7:0]        m_wid,
  output logic [46:0]       m_acmd,
  output logic              m_atype,
  output logic              m_avalid,
  input  logic              m_aready,
  output logic [DW-1:0]     m_wdata,
  output logic [DW/8-1:0]   m_wstrb,
  output logic              m_wlast,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [7:0]        m_rid,
  input  logic [DW-1:0]     m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [7:0]        m_bid,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [1:0]        grant,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRESP, RDATA} state_t;

  state_t      state, state_next;
  logic        g, g_next, last;
  logic [31:0] cnt;
  logic [7:0]  id;
  logic        sel_wvalid, sel_wlast, sel_bready, sel_rready;
  logic        stray, id_bad, timeout_hit;

  assign id         = {7'b0, g};
  assign m_aid      = id;
  assign m_wid      = id;
  assign s_rdata    = m_rdata;
  assign s_rresp    = m_rresp;
  assign s_rlast    = m_rlast;
  assign sel_wvalid = s_wvalid[g];
  assign sel_wlast  = s_wlast[g];
  assign sel_bready = s_bready[g];
  assign sel_rready = s_rready[g];

  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      g     <= 1'b0;
      grant <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == ADDR) begin
        g     <= g_next;
        grant <= g_next ? 2'b10 : 2'b01;
      end
      if (state != IDLE && state_next == IDLE) begin
        grant <= '0;
        last  <= g;
      end
    end
  end

  always_comb begin
    state_next = state;
    g_next     = g;
    unique case (state)
      IDLE: if (|s_avalid) begin
        // prefer the requester that did not own the previous transaction
        g_next     = s_avalid[~last] ? ~last : last;
        state_next = ADDR;
      end
      ADDR:  if (m_aready) state_next = s_atype[g] ? WDATA : RDATA;
      WDATA: if (sel_wvalid && m_wready && sel_wlast) state_next = WRESP;
      WRESP: if (m_bvalid && sel_bready) state_next = IDLE;
      RDATA: if (m_rvalid && sel_rready && m_rlast) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_aready = '0;
    s_wready = '0;
    s_rvalid = '0;
    s_bvalid = '0;
    m_acmd   = '0;
    m_atype  = 1'b0;
    m_avalid = 1'b0;
    m_wdata  = '0;
    m_wstrb  = '0;
    m_wlast  = 1'b0;
    m_wvalid = 1'b0;
    m_rready = 1'b0;
    m_bready = 1'b0;
    unique case (state)
      ADDR: begin
        m_avalid    = 1'b1;
        m_acmd      = g ? s_acmd[93:47] : s_acmd[46:0];
        m_atype     = s_atype[g];
        s_aready[g] = m_aready;
      end
      WDATA: begin
        m_wdata     = g ? s_wdata[2*DW-1:DW] : s_wdata[DW-1:0];
        m_wstrb     = g ? s_wstrb[2*DW/8-1:DW/8] : s_wstrb[DW/8-1:0];
        m_wlast     = sel_wlast;
        m_wvalid    = sel_wvalid;
        s_wready[g] = m_wready;
      end
      WRESP: begin
        s_bvalid[g] = m_bvalid;
        m_bready    = sel_bready;
      end
      RDATA: begin
        s_rvalid[g] = m_rvalid;
        m_rready    = sel_rready;
      end
      default: ;
    endcase
  end

  // timeout fires only when a phase is still unfinished after TIMEOUT cycles
  assign stray       = (m_bvalid && state != WRESP) || (m_rvalid && state != RDATA);
  assign id_bad      = (state == WRESP && m_bvalid && sel_bready && m_bid != id) ||
                       (state == RDATA && m_rvalid && sel_rready && m_rid != id);
  assign timeout_hit = (TIMEOUT != 0) && state != IDLE && state_next == state &&
                       cnt == 32'(TIMEOUT - 1);

  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (state == IDLE || state_next != state) cnt <= '0;
      else if (cnt < 32'(TIMEOUT)) cnt <= cnt + 1'b1;
      if (stray || id_bad || timeout_hit) err <= 1'b1;
    end
  end

endmodule
